// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction fetch stage of the 16-bit pipeline. Owns the program counter,
// reads one instruction word per cycle from a combinational instruction
// memory and loads the IF/ID pipeline register. Two-word LDM instructions are
// assembled here: the opcode word is parked in hold_q while a bubble goes to
// decode, and the following word is attached as the immediate.
//
// Optional feature (compile-time macro FETCH_RESET_VECTOR_EN):
//   When defined, reset first reads a 32-bit start address from memory
//   words 0 (high half) and 1 (low half) before normal fetching begins.
//   When undefined, fetching starts directly at PC = 0.
//
// Parameters:
//   PC_W      program counter / instruction address width (words)
//   NOP_WORD  instruction word presented to decode on a bubble
//   LDM_OPC   opcode (inst[15:11]) of the two-word LDM instruction
//
// Ports:
//   clk          clock, all state changes on the rising edge
//   rst          synchronous active-high reset
//   pc_enable    0 holds the PC and inserts bubbles (halt)
//   stall        1 freezes PC, fetch state and IF/ID
//   flush        discards IF/ID content and any pending LDM
//   jump_taken   redirect request from execute
//   jump_target  redirect address
//   imem_addr    instruction memory word address (the PC)
//   imem_data    instruction word at imem_addr
//   if_inst      IF/ID instruction word
//   if_imm       IF/ID immediate (meaningful only for LDM)
//   if_pc_next   address after the last word of the IF/ID instruction
//   if_valid     IF/ID holds a real instruction
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter int          PC_W     = 32,
    parameter logic [15:0] NOP_WORD = 16'h4000,
    parameter logic [4:0]  LDM_OPC  = 5'b10001
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pc_enable,
    input  logic            stall,
    input  logic            flush,
    input  logic            jump_taken,
    input  logic [PC_W-1:0] jump_target,
    output logic [PC_W-1:0] imem_addr,
    input  logic [15:0]     imem_data,
    output logic [15:0]     if_inst,
    output logic [15:0]     if_imm,
    output logic [PC_W-1:0] if_pc_next,
    output logic            if_valid
);

    typedef enum logic [1:0] {
        VEC_HI = 2'd0,
        VEC_LO = 2'd1,
        RUN    = 2'd2,
        IMM    = 2'd3
    } fetch_state_t;

`ifdef FETCH_RESET_VECTOR_EN
    localparam fetch_state_t RESET_STATE = VEC_HI;
`else
    localparam fetch_state_t RESET_STATE = RUN;
`endif

    fetch_state_t    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [15:0]     hold_q, hold_d;
    logic [15:0]     inst_q, inst_d;
    logic [15:0]     imm_q, imm_d;
    logic [PC_W-1:0] pc_next_q, pc_next_d;
    logic            valid_q, valid_d;
    logic [PC_W-1:0] pc_inc;
    logic            is_ldm;

    assign pc_inc    = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
    assign is_ldm    = (imem_data[15:11] == LDM_OPC);
    assign imem_addr = pc_q;

    assign if_inst    = inst_q;
    assign if_imm     = imm_q;
    assign if_pc_next = pc_next_q;
    assign if_valid   = valid_q;

`ifdef FETCH_RESET_VECTOR_EN
    logic [15:0]     pc_hi_q, pc_hi_d;
    logic [31:0]     vec_word;
    logic [PC_W-1:0] vec_pc;

    assign vec_word = {pc_hi_q, imem_data};

    // The start address is taken from the upper PC_W bits of the 32-bit
    // vector; narrower or wider PCs are handled at elaboration time.
    generate
        if (PC_W <= 32) begin : g_vec_narrow
            assign vec_pc = vec_word[31 -: PC_W];
        end else begin : g_vec_wide
            assign vec_pc = {{(PC_W-32){1'b0}}, vec_word};
        end
    endgenerate
`endif

    // Next-state and IF/ID computation. Everything holds by default; each
    // event then overrides only what it changes. A bubble leaves
    // if_pc_next untouched so the last return address stays visible.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        hold_d    = hold_q;
        inst_d    = inst_q;
        imm_d     = imm_q;
        pc_next_d = pc_next_q;
        valid_d   = valid_q;
`ifdef FETCH_RESET_VECTOR_EN
        pc_hi_d   = pc_hi_q;
`endif

        case (state_q)
`ifdef FETCH_RESET_VECTOR_EN
            VEC_HI: begin
                pc_hi_d = imem_data;
                pc_d    = {{(PC_W-1){1'b0}}, 1'b1};
                state_d = VEC_LO;
                inst_d  = NOP_WORD;
                imm_d   = 16'h0000;
                valid_d = 1'b0;
            end
            VEC_LO: begin
                pc_d    = vec_pc;
                state_d = RUN;
                inst_d  = NOP_WORD;
                imm_d   = 16'h0000;
                valid_d = 1'b0;
            end
`endif
            default: begin
                if (jump_taken) begin
                    pc_d    = jump_target;
                    state_d = RUN;
                    hold_d  = 16'h0000;
                    inst_d  = NOP_WORD;
                    imm_d   = 16'h0000;
                    valid_d = 1'b0;
                end else if (flush) begin
                    state_d = RUN;
                    hold_d  = 16'h0000;
                    inst_d  = NOP_WORD;
                    imm_d   = 16'h0000;
                    valid_d = 1'b0;
                    if (!stall && pc_enable) begin
                        pc_d = pc_inc;
                    end
                end else if (stall) begin
                    state_d = state_q;
                end else if (!pc_enable) begin
                    inst_d  = NOP_WORD;
                    imm_d   = 16'h0000;
                    valid_d = 1'b0;
                end else if (state_q == IMM) begin
                    pc_d      = pc_inc;
                    inst_d    = hold_q;
                    imm_d     = imem_data;
                    pc_next_d = pc_inc;
                    valid_d   = 1'b1;
                    state_d   = RUN;
                end else if (is_ldm) begin
                    pc_d    = pc_inc;
                    hold_d  = imem_data;
                    inst_d  = NOP_WORD;
                    imm_d   = 16'h0000;
                    valid_d = 1'b0;
                    state_d = IMM;
                end else begin
                    pc_d      = pc_inc;
                    inst_d    = imem_data;
                    imm_d     = 16'h0000;
                    pc_next_d = pc_inc;
                    valid_d   = 1'b1;
                end
            end
        endcase
    end

    // State register. Reset wins over every other input and abandons any
    // LDM that is waiting for its immediate.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RESET_STATE;
            pc_q      <= '0;
            hold_q    <= 16'h0000;
            inst_q    <= NOP_WORD;
            imm_q     <= 16'h0000;
            pc_next_q <= '0;
            valid_q   <= 1'b0;
`ifdef FETCH_RESET_VECTOR_EN
            pc_hi_q   <= 16'h0000;
`endif
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            hold_q    <= hold_d;
            inst_q    <= inst_d;
            imm_q     <= imm_d;
            pc_next_q <= pc_next_d;
            valid_q   <= valid_d;
`ifdef FETCH_RESET_VECTOR_EN
            pc_hi_q   <= pc_hi_d;
`endif
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//
// Self-checking bench for fetch_stage. A behavioural model of the fetch rules
// (PC, pending LDM flag, IF/ID contents) is advanced on every rising edge from
// the same inputs and its own copy of the PC; the DUT outputs are compared
// against it one time unit after the edge. Directed scenarios come first,
// followed by a randomized run.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

    localparam int          PC_W     = 32;
    localparam logic [15:0] NOP_WORD = 16'h4000;
    localparam logic [4:0]  LDM_OPC  = 5'b10001;

`ifdef FETCH_RESET_VECTOR_EN
    localparam bit VEC_EN = 1'b1;
`else
    localparam bit VEC_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            pc_enable = 1'b1;
    logic            stall = 1'b0;
    logic            flush = 1'b0;
    logic            jump_taken = 1'b0;
    logic [PC_W-1:0] jump_target = '0;
    logic [PC_W-1:0] imem_addr;
    logic [15:0]     imem_data;
    logic [15:0]     if_inst;
    logic [15:0]     if_imm;
    logic [PC_W-1:0] if_pc_next;
    logic            if_valid;

    logic [15:0] mem [0:1023];

    int test_count = 0;
    int fail_count = 0;

    // Reference model state
    logic [31:0] m_pc;
    bit          m_pending;
    logic [15:0] m_hold;
    logic [15:0] m_inst;
    logic [15:0] m_imm;
    logic [31:0] m_pcn;
    bit          m_valid;
    int          m_vec;
    logic [15:0] m_pchi;

    fetch_stage #(
        .PC_W     (PC_W),
        .NOP_WORD (NOP_WORD),
        .LDM_OPC  (LDM_OPC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pc_enable   (pc_enable),
        .stall       (stall),
        .flush       (flush),
        .jump_taken  (jump_taken),
        .jump_target (jump_target),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .if_inst     (if_inst),
        .if_imm      (if_imm),
        .if_pc_next  (if_pc_next),
        .if_valid    (if_valid)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Combinational instruction memory, low address bits only
    assign imem_data = mem[imem_addr[9:0]];

    // Single comparison point for the whole bench
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        test_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic modelBubble();
        m_inst  = NOP_WORD;
        m_imm   = 16'h0000;
        m_valid = 1'b0;
    endtask

    // Advance the model by one clock edge using the fetch rules directly
    task automatic modelStep(input bit r, input bit pe, input bit st, input bit fl,
                             input bit jt, input logic [31:0] tgt);
        logic [15:0] w;
        logic [31:0] vec;
        w = mem[m_pc[9:0]];
        if (r) begin
            modelBubble();
            m_pcn     = 0;
            m_hold    = 0;
            m_pending = 0;
            m_pc      = 0;
            m_vec     = VEC_EN ? 1 : 0;
        end else if (m_vec == 1) begin
            m_pchi = w;
            m_pc   = 1;
            m_vec  = 2;
            modelBubble();
        end else if (m_vec == 2) begin
            vec   = {m_pchi, w};
            m_pc  = vec;
            m_vec = 0;
            modelBubble();
        end else if (jt) begin
            m_pc      = tgt;
            m_pending = 0;
            modelBubble();
        end else if (fl) begin
            m_pending = 0;
            modelBubble();
            if (!st && pe) m_pc = m_pc + 1;
        end else if (st) begin
            m_pending = m_pending;
        end else if (!pe) begin
            modelBubble();
        end else begin
            if (m_pending) begin
                m_inst    = m_hold;
                m_imm     = w;
                m_pcn     = m_pc + 1;
                m_valid   = 1'b1;
                m_pending = 0;
            end else if (w[15:11] == LDM_OPC) begin
                m_hold    = w;
                m_pending = 1;
                modelBubble();
            end else begin
                m_inst  = w;
                m_imm   = 16'h0000;
                m_pcn   = m_pc + 1;
                m_valid = 1'b1;
            end
            m_pc = m_pc + 1;
        end
    endtask

    // Drive one cycle of inputs, step the model at the edge, compare after it
    task automatic applyStimulus(input bit r, input bit pe, input bit st, input bit fl,
                                 input bit jt, input logic [31:0] tgt);
        @(negedge clk);
        rst         = r;
        pc_enable   = pe;
        stall       = st;
        flush       = fl;
        jump_taken  = jt;
        jump_target = tgt;
        @(posedge clk);
        modelStep(r, pe, st, fl, jt, tgt);
        #1;
        checkOutput("imem_addr",  imem_addr,          m_pc);
        checkOutput("if_inst",    {16'h0, if_inst},   {16'h0, m_inst});
        checkOutput("if_imm",     {16'h0, if_imm},    {16'h0, m_imm});
        checkOutput("if_pc_next", if_pc_next,         m_pcn);
        checkOutput("if_valid",   {31'h0, if_valid},  {31'h0, m_valid});
    endtask

    task automatic fillMem();
        for (int i = 0; i < 1024; i++) mem[i] = 16'h0800 | 16'(i);
    endtask

    task automatic normalCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 1, 0, 0, 0, 0);
    endtask

    initial begin
        logic [31:0] tgt;
        bit r, pe, st, fl, jt;

        m_pc = 0; m_pending = 0; m_hold = 0; m_inst = NOP_WORD; m_imm = 0;
        m_pcn = 0; m_valid = 0; m_vec = 0; m_pchi = 0;
        fillMem();

`ifdef FETCH_RESET_VECTOR_EN
        // Reset vector: two bubbles, then fetching from 0x100
        mem[0] = 16'h0000;
        mem[1] = 16'h0100;
        applyStimulus(1, 1, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0);
        checkOutput("vec_bubble1", {31'h0, if_valid}, 32'h0);
        applyStimulus(0, 0, 1, 1, 1, 32'h55);
        checkOutput("vec_bubble2", {31'h0, if_valid}, 32'h0);
        checkOutput("vec_start_pc", imem_addr, 32'h0000_0100);
        normalCycles(2);
        fillMem();
`endif

        // Straight-line fetch
        mem[0] = 16'h1000; mem[1] = 16'h2000; mem[2] = 16'h3000;
        applyStimulus(1, 1, 0, 0, 0, 0);
`ifndef FETCH_RESET_VECTOR_EN
        checkOutput("rst_inst", {16'h0, if_inst}, {16'h0, NOP_WORD});
        checkOutput("rst_pc", imem_addr, 32'h0);
`endif
        normalCycles(3);
`ifndef FETCH_RESET_VECTOR_EN
        checkOutput("seq_c3_inst", {16'h0, if_inst}, 32'h3000);
        checkOutput("seq_c3_pcn", if_pc_next, 32'h3);
`endif

        // LDM assembled from two words with one bubble
        mem[0] = 16'h8C00; mem[1] = 16'h00AB; mem[2] = 16'h1234;
        applyStimulus(1, 1, 0, 0, 0, 0);
        normalCycles(2);
`ifndef FETCH_RESET_VECTOR_EN
        checkOutput("ldm_inst", {16'h0, if_inst}, 32'h8C00);
        checkOutput("ldm_imm", {16'h0, if_imm}, 32'h00AB);
        checkOutput("ldm_pcn", if_pc_next, 32'h2);
        checkOutput("ldm_pc", imem_addr, 32'h2);
`endif

        // Stall for three cycles while the LDM waits for its immediate
        applyStimulus(1, 1, 0, 0, 0, 0);
        normalCycles(1);
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 1, 0, 0, 0);
`ifndef FETCH_RESET_VECTOR_EN
        checkOutput("stall_pc", imem_addr, 32'h1);
`endif
        normalCycles(1);
`ifndef FETCH_RESET_VECTOR_EN
        checkOutput("stall_ldm_imm", {16'h0, if_imm}, 32'h00AB);
`endif

        // Jump beats stall
        applyStimulus(0, 1, 1, 0, 1, 32'h40);
        checkOutput("jump_pc", imem_addr, 32'h40);
        checkOutput("jump_valid", {31'h0, if_valid}, 32'h0);

        // Flush while an LDM is pending
        mem[12'h40] = 16'h8C11; mem[12'h41] = 16'h2222; mem[12'h42] = 16'h3333;
        normalCycles(1);
        applyStimulus(0, 1, 0, 1, 0, 0);
        normalCycles(2);

        // Halt for two cycles
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        normalCycles(1);

        // PC wrap at all-ones
        applyStimulus(0, 1, 0, 0, 1, 32'hFFFF_FFFF);
        normalCycles(1);
        checkOutput("wrap_pc", imem_addr, 32'h0);
        checkOutput("wrap_pcn", if_pc_next, 32'h0);

        // Randomized run over memory seeded with LDM words
        for (int i = 0; i < 1024; i++) begin
            mem[i] = 16'($urandom);
            if ($urandom_range(0, 3) == 0) mem[i][15:11] = LDM_OPC;
        end
        applyStimulus(1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 600; i++) begin
            r  = ($urandom_range(0, 63) == 0);
            jt = ($urandom_range(0, 15) == 0);
            fl = ($urandom_range(0, 15) == 0);
            st = ($urandom_range(0, 4) == 0);
            pe = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            else tgt = 32'($urandom_range(0, 1023));
            applyStimulus(r, pe, st, fl, jt, tgt);
        end

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
